lte_dw_dfe_xant_deserializer: RTL and testbench

//  Downstream of the 8-antenna transpose/antenna-switch stage on the 491.52 MHz domain.

---
 rtl/lte_dw_dfe_xant_deserializer_if.sv | 31 +++
 rtl/lte_dw_dfe_xant_deserializer.sv | 116 +++++++++++
 tb/tb_lte_dw_dfe_xant_deserializer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/lte_dw_dfe_xant_deserializer_if.sv
// Purpose : bundles the serial word stream from the antenna-switch stage and the
//           paired IQ sample stream out of the deserializer.
// Ports   : i_mod_sel/i_fram/i_xant/i_data (upstream -> deserializer),
//           o_vld/o_sof/o_ant/o_data/o_align/o_err/o_err_cnt (deserializer -> downstream).
// Modports: master = upstream word source / downstream observer, slave = deserializer.
interface lte_dw_dfe_xant_deserializer_if #(
  parameter int NUM_ANT_W = 3,
  parameter int ERR_CNT_W = 16
);
  logic [1:0]           i_mod_sel;
  logic                 i_fram;
  logic                 i_xant;
  logic [15:0]          i_data;
  logic                 o_vld;
  logic                 o_sof;
  logic [NUM_ANT_W-1:0] o_ant;
  logic [31:0]          o_data;
  logic                 o_align;
  logic                 o_err;
  logic [ERR_CNT_W-1:0] o_err_cnt;

  modport master (
    output i_mod_sel, i_fram, i_xant, i_data,
    input  o_vld, o_sof, o_ant, o_data, o_align, o_err, o_err_cnt
  );

  modport slave (
    input  i_mod_sel, i_fram, i_xant, i_data,
    output o_vld, o_sof, o_ant, o_data, o_align, o_err, o_err_cnt
  );
endinterface

// File: rtl/lte_dw_dfe_xant_deserializer.sv
// Purpose : re-pairs serial Q/I words into 32-bit IQ samples tagged with antenna index,
//           checks the antenna-block period against the bandwidth mode.
// Latency : 1 cycle from the I word to o_vld.
// Backpressure: none; the word stream is free-running and must be consumed every cycle.
// Ports   : sys_clk_491p52, sys_rst_491p52 (sync, active-high), bus (slave modport:
//           i_mod_sel/i_fram/i_xant/i_data in, o_vld/o_sof/o_ant/o_data/o_align/o_err/o_err_cnt out).
// Option  : define LTE_DW_XANT_DES_STAT_EN to build the saturating violation counter;
//           otherwise o_err_cnt is tied to zero.
module lte_dw_dfe_xant_deserializer #(
  parameter int NUM_ANT_W = 3,
  parameter int ERR_CNT_W = 16
) (
  input  logic                          sys_clk_491p52,
  input  logic                          sys_rst_491p52,
  lte_dw_dfe_xant_deserializer_if.slave bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [5:0]  word_cnt;   // index of the last accepted word within its block
  logic [5:0]  period_m1;  // block period minus one
  logic [15:0] q_hold;
  logic        sof_pend;   // first sample of the frame not yet emitted

  logic [5:0]  cnt_inc;
  logic [5:0]  cur_idx;    // index of the word presented this cycle
  logic        early_viol;
  logic        late_viol;
  logic        viol;

  function automatic logic [5:0] period_m1_of(input logic [1:0] sel);
    case (sel)
      2'd0:       return 6'd63;
      2'd1, 2'd2: return 6'd31;
      default:    return 6'd15;
    endcase
  endfunction

  always_comb begin
    cnt_inc    = (word_cnt == period_m1) ? 6'd0 : word_cnt + 6'd1;
    cur_idx    = (bus.i_fram || bus.i_xant) ? 6'd0 : cnt_inc;
    // A frame head overrides any boundary check on the same cycle.
    early_viol = (state == ST_RUN) && !bus.i_fram && bus.i_xant && (word_cnt != period_m1);
    late_viol  = (state == ST_RUN) && !bus.i_fram && !bus.i_xant && (word_cnt == period_m1);
    viol       = early_viol || late_viol;
  end

  always_ff @(posedge sys_clk_491p52) begin
    if (sys_rst_491p52) begin
      state       <= ST_IDLE;
      word_cnt    <= 6'd0;
      period_m1   <= 6'd15;
      q_hold      <= 16'd0;
      sof_pend    <= 1'b0;
      bus.o_vld   <= 1'b0;
      bus.o_sof   <= 1'b0;
      bus.o_ant   <= '0;
      bus.o_data  <= 32'd0;
      bus.o_align <= 1'b0;
      bus.o_err   <= 1'b0;
    end else begin
      bus.o_vld <= 1'b0;
      bus.o_sof <= 1'b0;
      bus.o_err <= 1'b0;
      if (bus.i_fram) begin
        // Restart from any state; the frame head word is always a Q word.
        state       <= ST_RUN;
        bus.o_align <= 1'b1;
        period_m1   <= period_m1_of(bus.i_mod_sel);
        word_cnt    <= 6'd0;
        q_hold      <= bus.i_data;
        sof_pend    <= 1'b1;
      end else if (state == ST_RUN) begin
        if (viol) begin
          // Drop out of alignment; any held Q is abandoned.
          state       <= ST_IDLE;
          bus.o_align <= 1'b0;
          bus.o_err   <= 1'b1;
          sof_pend    <= 1'b0;
        end else begin
          word_cnt <= cur_idx;
          if (!cur_idx[0]) begin
            q_hold <= bus.i_data;
          end else begin
            bus.o_vld  <= 1'b1;
            bus.o_sof  <= sof_pend;
            sof_pend   <= 1'b0;
            bus.o_ant  <= cur_idx[NUM_ANT_W:1];
            bus.o_data <= {bus.i_data, q_hold};
          end
        end
      end
    end
  end

`ifdef LTE_DW_XANT_DES_STAT_EN
  logic [ERR_CNT_W-1:0] err_cnt;

  always_ff @(posedge sys_clk_491p52) begin
    if (sys_rst_491p52) begin
      err_cnt <= '0;
    end else if (viol && !(&err_cnt)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign bus.o_err_cnt = err_cnt;
`else
  assign bus.o_err_cnt = {ERR_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_lte_dw_dfe_xant_deserializer.sv
// Purpose : directed self-checking bench for lte_dw_dfe_xant_deserializer.
// Latency : outputs sampled 1 ns after the edge that registers each word.
// Backpressure: none exercised; the stream is driven every cycle.
module tb_lte_dw_dfe_xant_deserializer;

`ifdef LTE_DW_XANT_DES_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic sys_clk_491p52 = 1'b0;
  logic sys_rst_491p52;
  int   n_cmp = 0;
  int   n_mis = 0;

  lte_dw_dfe_xant_deserializer_if bus ();

  lte_dw_dfe_xant_deserializer dut (
    .sys_clk_491p52 (sys_clk_491p52),
    .sys_rst_491p52 (sys_rst_491p52),
    .bus            (bus)
  );

  always #5 sys_clk_491p52 = ~sys_clk_491p52;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Present one word, clock it in, return just after the edge.
  task automatic drive(input logic fram, input logic xant, input logic [15:0] data,
                       input logic [1:0] ms);
    bus.i_fram    = fram;
    bus.i_xant    = xant;
    bus.i_data    = data;
    bus.i_mod_sel = ms;
    @(posedge sys_clk_491p52);
    #1;
  endtask

  // Send n aligned words base+0 .. base+n-1; the first carries fram/xant as given.
  task automatic send_run(input int n, input logic fram, input logic xant,
                          input logic [1:0] ms, input logic [15:0] base);
    logic [15:0] d;
    int          nv;
    nv = 0;
    for (int w = 0; w < n; w++) begin
      d = base + 16'(w);
      drive(fram && (w == 0), xant && (w == 0), d, ms);
      chk_val("err", 32'(bus.o_err), 32'd0);
      chk_val("align", 32'(bus.o_align), 32'd1);
      chk_val("vld", 32'(bus.o_vld), 32'(w % 2));
      nv += int'(bus.o_vld);
      if (w % 2 == 1) begin
        chk_val("ant", 32'(bus.o_ant), 32'((w >> 1) & 7));
        chk_val("data", bus.o_data, {d, d - 16'd1});
        chk_val("sof", 32'(bus.o_sof), 32'(fram && (w == 1)));
      end
    end
    chk_val("vld_count", 32'(nv), 32'(n / 2));
  endtask

  // Words and xant pulses while unaligned: nothing may come out.
  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, (k % 5) == 0, 16'hA000 + 16'(k), 2'd3);
      chk_val("idle_vld", 32'(bus.o_vld), 32'd0);
      chk_val("idle_err", 32'(bus.o_err), 32'd0);
      chk_val("idle_align", 32'(bus.o_align), 32'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_val({tag, "_vld"}, 32'(bus.o_vld), 32'd0);
    chk_val({tag, "_sof"}, 32'(bus.o_sof), 32'd0);
    chk_val({tag, "_ant"}, 32'(bus.o_ant), 32'd0);
    chk_val({tag, "_data"}, bus.o_data, 32'd0);
    chk_val({tag, "_align"}, 32'(bus.o_align), 32'd0);
    chk_val({tag, "_err"}, 32'(bus.o_err), 32'd0);
    chk_val({tag, "_errcnt"}, 32'(bus.o_err_cnt), 32'd0);
  endtask

  initial begin
    sys_rst_491p52 = 1'b1;
    bus.i_fram     = 1'b0;
    bus.i_xant     = 1'b0;
    bus.i_data     = 16'd0;
    bus.i_mod_sel  = 2'd0;

    // Reset state
    drive(1'b0, 1'b0, 16'h1234, 2'd0);
    drive(1'b0, 1'b1, 16'h5678, 2'd0);
    chk_reset_outputs("rst");
    sys_rst_491p52 = 1'b0;
    idle_check(6);

    // 20 MHz, P=16: first sample 0x00010000 with sof, ants 0..7
    send_run(16, 1'b1, 1'b0, 2'd3, 16'h0000);
    send_run(16, 1'b0, 1'b1, 2'd3, 16'h0010);
    send_run(16, 1'b0, 1'b1, 2'd3, 16'h0020);

    // 5 MHz, P=64: 32 samples per block, ant rotation repeats 4x
    send_run(64, 1'b1, 1'b0, 2'd0, 16'h1000);
    send_run(64, 1'b0, 1'b1, 2'd0, 16'h2000);

    // 15 MHz, P=32: early xant at word 20
    send_run(20, 1'b1, 1'b0, 2'd2, 16'h3000);
    drive(1'b0, 1'b1, 16'h3014, 2'd2);
    chk_val("early_err", 32'(bus.o_err), 32'd1);
    chk_val("early_align", 32'(bus.o_align), 32'd0);
    chk_val("early_vld", 32'(bus.o_vld), 32'd0);
    idle_check(8);
    chk_val("early_errcnt", 32'(bus.o_err_cnt), STAT ? 32'd1 : 32'd0);

    // 10 MHz, P=32: missing xant after word 31
    send_run(32, 1'b1, 1'b0, 2'd1, 16'h4000);
    drive(1'b0, 1'b0, 16'hBEEF, 2'd1);
    chk_val("late_err", 32'(bus.o_err), 32'd1);
    chk_val("late_align", 32'(bus.o_align), 32'd0);
    chk_val("late_vld", 32'(bus.o_vld), 32'd0);
    idle_check(4);
    chk_val("late_errcnt", 32'(bus.o_err_cnt), STAT ? 32'd2 : 32'd0);

    // fram+xant together mid-block, mode 3 -> 1: restart with P=32, no error
    send_run(16, 1'b1, 1'b0, 2'd3, 16'h5000);
    send_run(7, 1'b0, 1'b1, 2'd3, 16'h5100);
    send_run(32, 1'b1, 1'b1, 2'd1, 16'h5200);
    send_run(32, 1'b0, 1'b1, 2'd3, 16'h5300);
    chk_val("restart_errcnt", 32'(bus.o_err_cnt), STAT ? 32'd2 : 32'd0);

    // Reset right after a Q word
    send_run(3, 1'b1, 1'b0, 2'd3, 16'h6000);
    sys_rst_491p52 = 1'b1;
    drive(1'b0, 1'b0, 16'h6003, 2'd3);
    chk_reset_outputs("midrst");
    sys_rst_491p52 = 1'b0;
    idle_check(20);
    send_run(16, 1'b1, 1'b0, 2'd3, 16'h7000);
    send_run(16, 1'b0, 1'b1, 2'd3, 16'h7100);
    chk_val("final_errcnt", 32'(bus.o_err_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
